// File: rtl/fp_divider.sv
// Sequential IEEE-754 single-precision divider: 25-step restoring mantissa
// division with flush-to-zero, truncation and saturation, one-cycle done pulse.
module fp_divider (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] q,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {IDLE, CHECK, DIV, NORM, FIN} state_t;

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [31:0] res_q, res_d, q_q, q_d;
    logic [24:0] r_q, r_d, qm_q, qm_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        done_q, done_d;

    logic        sa, sb, sq;
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic        spec_hit;
    logic [31:0] spec_val;
    logic [23:0] ma, mb;
    logic        ge;
    logic [24:0] r_sub;
    logic signed [9:0] e_norm;
    logic [22:0] mant;

    // Saturate the signed biased exponent into the final packed word.
    function automatic logic [31:0] pack_result(input logic sgn,
                                                input logic signed [9:0] e,
                                                input logic [22:0] m);
        if (e >= 10'sd255)
            return {sgn, 8'hFF, 23'd0};
        else if (e <= 10'sd0)
            return {sgn, 31'd0};
        else
            return {sgn, e[7:0], m};
    endfunction

    assign sa = a_q[31];
    assign sb = b_q[31];
    assign ea = a_q[30:23];
    assign eb = b_q[30:23];
    assign fa = a_q[22:0];
    assign fb = b_q[22:0];
    assign sq = sa ^ sb;
    assign ma = {1'b1, fa};
    assign mb = {1'b1, fb};

    // Denormals count as zero: only the exponent field decides.
    assign a_zero = (ea == 8'h00);
    assign b_zero = (eb == 8'h00);
    assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
    assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
    assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
    assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);

    always_comb begin
        spec_hit = 1'b1;
        spec_val = 32'd0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
            spec_val = 32'h7FC00000;
        else if (a_inf || b_zero)
            spec_val = {sq, 8'hFF, 23'd0};
        else if (a_zero || b_inf)
            spec_val = {sq, 31'd0};
        else
            spec_hit = 1'b0;
    end

    assign ge    = (r_q >= {1'b0, mb});
    assign r_sub = ge ? (r_q - {1'b0, mb}) : r_q;

    always_comb begin
        if (qm_q[24]) begin
            mant   = qm_q[23:1];
            e_norm = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
        end else begin
            mant   = qm_q[22:0];
            e_norm = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd126;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        q_d     = q_q;
        r_d     = r_q;
        qm_d    = qm_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (spec_hit) begin
                    res_d   = spec_val;
                    state_d = FIN;
                end else begin
                    r_d     = {1'b0, ma};
                    qm_d    = 25'd0;
                    cnt_d   = 5'd24;
                    state_d = DIV;
                end
            end
            DIV: begin
                qm_d[cnt_q] = ge;
                r_d         = {r_sub[23:0], 1'b0};
                if (cnt_q == 5'd0)
                    state_d = NORM;
                else
                    cnt_d = cnt_q - 5'd1;
            end
            NORM: begin
                res_d   = pack_result(sq, e_norm, mant);
                state_d = FIN;
            end
            FIN: begin
                // q and done update on the same edge so q never changes early.
                q_d     = res_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            res_q   <= 32'd0;
            q_q     <= 32'd0;
            r_q     <= 25'd0;
            qm_q    <= 25'd0;
            cnt_q   <= 5'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            q_q     <= q_d;
            r_q     <= r_d;
            qm_q    <= qm_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign q    = q_q;
    assign done = done_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_fp_divider.sv
// Directed bench for fp_divider: normal, special, saturation, handshake,
// back-to-back and mid-operation reset scenarios with hand-computed results.
module tb_fp_divider;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic        busy;
    logic        done;

    int n_checks;
    int n_fail;

    fp_divider dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .q     (q),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one operation and measure edges until done (-1 on timeout).
    task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                          output logic [31:0] qo, output int lat);
        @(negedge clk);
        start = 1'b1;
        a     = av;
        b     = bv;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        lat   = -1;
        qo    = 32'hDEADBEEF;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                qo  = q;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        a     = 32'd0;
        b     = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (q !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_q got %h want %h", q, 32'd0);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy got %b want 0", busy);
        end
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_done got %b want 0", done);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_vectors(input string tag, input int exp_lat);
        logic [31:0] va [4];
        logic [31:0] vb [4];
        logic [31:0] vq [4];
        int          nv;
        logic [31:0] qo;
        int          lat;
        nv = 0;
        if (tag == "normal") begin
            va[0] = 32'h41000000; vb[0] = 32'h40000000; vq[0] = 32'h40800000;
            va[1] = 32'h3F800000; vb[1] = 32'h40400000; vq[1] = 32'h3EAAAAAA;
            va[2] = 32'hC0C80000; vb[2] = 32'h40200000; vq[2] = 32'hC0200000;
            nv = 3;
        end else if (tag == "special") begin
            va[0] = 32'h40A00000; vb[0] = 32'h00000000; vq[0] = 32'h7F800000;
            va[1] = 32'h00000000; vb[1] = 32'h00000000; vq[1] = 32'h7FC00000;
            va[2] = 32'h80000000; vb[2] = 32'h40000000; vq[2] = 32'h80000000;
            va[3] = 32'h7F800000; vb[3] = 32'h7F800000; vq[3] = 32'h7FC00000;
            nv = 4;
        end else begin
            va[0] = 32'h7F000000; vb[0] = 32'h00800000; vq[0] = 32'h7F800000;
            va[1] = 32'h00800000; vb[1] = 32'h7F000000; vq[1] = 32'h00000000;
            nv = 2;
        end
        for (int i = 0; i < nv; i++) begin
            run_op(va[i], vb[i], qo, lat);
            n_checks++;
            if (qo !== vq[i]) begin
                n_fail++;
                $display("FAIL %s_q[%0d] %h/%h got %h want %h", tag, i, va[i], vb[i], qo, vq[i]);
            end
            n_checks++;
            if (lat != exp_lat) begin
                n_fail++;
                $display("FAIL %s_latency[%0d] got %0d want %0d", tag, i, lat, exp_lat);
            end
        end
    endtask

    task automatic test_handshake;
        int dones;
        int busy_low;
        dones    = 0;
        busy_low = 0;
        @(negedge clk);
        start = 1'b1;
        a     = 32'h41000000;
        b     = 32'h40000000;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 32'h3F800000;
        b     = 32'h40400000;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            start = (i == 4);
            if (done) dones++;
            if (i < 28 && !busy) busy_low++;
        end
        start = 1'b0;
        n_checks++;
        if (dones != 1) begin
            n_fail++;
            $display("FAIL handshake_done_count got %0d want 1", dones);
        end
        n_checks++;
        if (q !== 32'h40800000) begin
            n_fail++;
            $display("FAIL handshake_q got %h want %h", q, 32'h40800000);
        end
        n_checks++;
        if (busy_low != 0) begin
            n_fail++;
            $display("FAIL handshake_busy_low_cycles got %0d want 0", busy_low);
        end
    endtask

    task automatic test_back_to_back;
        int dones;
        int drained;
        dones   = 0;
        drained = 0;
        @(negedge clk);
        start = 1'b1;
        a     = 32'h41000000;
        b     = 32'h40000000;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) begin
                drained = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (dones != 2) begin
            n_fail++;
            $display("FAIL b2b_done_count got %0d want 2", dones);
        end
        n_checks++;
        if (drained != 1) begin
            n_fail++;
            $display("FAIL b2b_drain got busy=%b want 0", busy);
        end
        n_checks++;
        if (q !== 32'h40800000) begin
            n_fail++;
            $display("FAIL b2b_q got %h want %h", q, 32'h40800000);
        end
    endtask

    task automatic test_reset_abort;
        int          dones;
        logic [31:0] qo;
        int          lat;
        dones = 0;
        @(negedge clk);
        start = 1'b1;
        a     = 32'h3F800000;
        b     = 32'h40400000;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_busy got %b want 0", busy);
        end
        n_checks++;
        if (q !== 32'd0) begin
            n_fail++;
            $display("FAIL abort_q got %h want %h", q, 32'd0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        n_checks++;
        if (dones != 0) begin
            n_fail++;
            $display("FAIL abort_done_count got %0d want 0", dones);
        end
        run_op(32'h3F800000, 32'h40400000, qo, lat);
        n_checks++;
        if (qo !== 32'h3EAAAAAA) begin
            n_fail++;
            $display("FAIL after_abort_q got %h want %h", qo, 32'h3EAAAAAA);
        end
        n_checks++;
        if (lat != 28) begin
            n_fail++;
            $display("FAIL after_abort_latency got %0d want 28", lat);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_vectors("normal", 28);
        test_vectors("special", 2);
        test_vectors("saturation", 28);
        test_handshake();
        test_back_to_back();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
